// File: rtl/dmem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake with fixed response latency.
// Optional address range checking is enabled by defining DMEM_RANGE_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic MULTI_CYCLE = (LATENCY > 1) ? 1'b1 : 1'b0;
  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [3:0]      count;
  logic            we;
  logic [AW-1:0]   idx;
  logic [31:0]     wdata;
  logic            err;
  logic            err_resp;
  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic            enter_resp;
  logic            addr_err;
  logic            cur_we;
  logic [AW-1:0]   cur_idx;
  logic [31:0]     cur_wdata;
  logic            cur_err;
  logic            commit;
  logic            unused;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

`ifdef DMEM_RANGE_CHECK_EN
  assign addr_err = |req_addr[31:AW+2];
`else
  assign addr_err = 1'b0;
`endif

  assign unused = ^{req_addr[31:AW+2], req_addr[1:0]};

  // With LATENCY=1 the accepting edge is also the edge entering RESP, so take the live request then.
  assign cur_we    = (state == IDLE) ? req_we              : we;
  assign cur_idx   = (state == IDLE) ? req_addr[AW+1:2]    : idx;
  assign cur_wdata = (state == IDLE) ? req_wdata           : wdata;
  assign cur_err   = (state == IDLE) ? addr_err            : err;
  assign commit    = enter_resp && cur_we && !cur_err && !reset;

  // Next-state logic; enter_resp marks the edge where the response is produced.
  always_comb begin
    next_state = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (MULTI_CYCLE) begin
            next_state = WAIT;
          end else begin
            next_state = RESP;
            enter_resp = 1'b1;
          end
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (count == 4'd0) begin
          next_state = RESP;
          enter_resp = 1'b1;
        end else begin
          next_state = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end else begin
          next_state = RESP;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, latency counter and latched request fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 4'd0;
      we    <= 1'b0;
      idx   <= '0;
      wdata <= 32'd0;
      err   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        count <= COUNT_LOAD;
        we    <= req_we;
        idx   <= req_addr[AW+1:2];
        wdata <= req_wdata;
        err   <= addr_err;
      end else if ((state == WAIT) && (count != 4'd0)) begin
        count <= count - 4'd1;
      end
    end
  end

  // Response register: loaded on entry to RESP and held until the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      err_resp  <= 1'b0;
    end else if (enter_resp) begin
      rsp_valid <= 1'b1;
      err_resp  <= cur_err;
      rsp_rdata <= (cur_we || cur_err) ? 32'd0 : mem[cur_idx];
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Array write; contents survive reset and only commit on the RESP entry edge.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  assign rsp_err = err_resp;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder (DEPTH=64, LATENCY=2).
module tb_dmem_responder;

  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  // Acceptance / response monitor for the back-to-back test.
  bit mon_en = 1'b0;
  int cyc = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;
  int last_acc = 0;
  int min_gap = 1000;

  dmem_responder #(.DEPTH(64), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mon_en && req_valid && req_ready) begin
      if (acc_cnt > 0 && (cyc - last_acc) < min_gap) min_gap <= cyc - last_acc;
      last_acc <= cyc;
      acc_cnt  <= acc_cnt + 1;
    end
    if (mon_en && rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, input string tag);
    int n;
    int lat;
    logic [31:0] first;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (!rsp_valid) chk({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LATENCY));
    chk({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, "_err"}, 32'(rsp_err), {31'd0, v.exp_err});
    first = rsp_rdata;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata, first);
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_done_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    logic range_en;
`ifdef DMEM_RANGE_CHECK_EN
    range_en = 1'b1;
`else
    range_en = 1'b0;
`endif
    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,  32'hCAFEF00D, 0, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h20,  32'h0,        5, 32'hCAFEF00D, 1'b0};
    vecs[4]  = '{1'b1, 32'h00,  32'h11111111, 0, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 32'h100, 32'hAAAA5555, 0, 32'h0,        range_en};
    vecs[6]  = '{1'b0, 32'h00,  32'h0,        0, range_en ? 32'h11111111 : 32'hAAAA5555, 1'b0};
    vecs[7]  = '{1'b1, 32'hFC,  32'h5A5A5A5A, 1, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 32'hFF,  32'h0,        0, 32'h5A5A5A5A, 1'b0};
    vecs[9]  = '{1'b0, 32'h13,  32'h0,        2, 32'hDEADBEEF, 1'b0};
    vecs[10] = '{1'b1, 32'h08,  32'h0BADF00D, 0, 32'h0,        1'b0};

    reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 11; i++) run_req(vecs[i], $sformatf("vec%0d", i));

    // Reset during WAIT abandons an uncommitted write.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h08;
    req_wdata = 32'h12345678;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_ready_after", 32'(req_ready), 32'd1);
    v = '{1'b0, 32'h08, 32'h0, 0, 32'h0BADF00D, 1'b0};
    run_req(v, "abort_read");

    // Back-to-back: req_valid held high continuously.
    @(negedge clk);
    mon_en    = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    rsp_ready = 1'b1;
    repeat (20) @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    mon_en    = 1'b0;
    rsp_ready = 1'b0;
    chk("b2b_min_gap", 32'(min_gap >= 3), 32'd1);
    chk("b2b_accepts", 32'(acc_cnt >= 4), 32'd1);
    chk("b2b_no_loss", 32'(rsp_cnt), 32'(acc_cnt));
    chk("b2b_idle", 32'(rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
